rate_tick_selector: RTL and testbench

Parametrised successor to the irrigation clock selector. It derives one-cycle `tick` enables and a 50 % duty `new_clock` from the system clock, at a rate chosen by priority logic over the irrigation, cleaning, error and valve status inputs. All logic sits in the single `clock` domain, with no divided or gated clocks. Rate changes occur only at period boundaries (glitch-free) or, optionally, immediately with a counter restart. Downstream FSMs (irrigation, cleaning, display blink) use `tick` as a clock enable.

---
 rtl/rate_tick_selector.sv | 195 +++++++++++++++++++
 tb/tb_rate_tick_selector.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_selector.sv
// rate_tick_selector
//
// Derives a one-cycle `tick` clock enable and a 50 % duty `new_clock` from the
// system clock. The tick period is chosen from 2^SEL_W rates by a priority
// encoder over the irrigation, cleaning, error and valve inputs. Everything
// runs in the `clock` domain. No divided or gated clocks are produced.
//
// Rate code k has period P(k) = BASE_DIV << (k*STEP) clock cycles.
// SWITCH_MODE = 0 : a new rate takes effect only at a period boundary.
// SWITCH_MODE = 1 : a new rate takes effect at once and restarts the count.
//
// Ports
//   clock        in  system clock, rising edge
//   reset        in  synchronous, active-high reset
//   rega         in  irrigation mode (01, 10, 00)
//   limpeza      in  cleaning status, bit 1 = cleaning active
//   erro         in  error flag
//   VE           in  valve-open flag
//   force_en     in  manual override enable
//   force_sel    in  manual override rate code
//   tick         out one-cycle pulse per selected period
//   new_clock    out toggles on every tick (period 2*P)
//   cur_sel      out active rate code
//   sel_changed  out one-cycle pulse in the first cycle cur_sel shows a new code
module rate_tick_selector #(
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned BASE_DIV    = 25_000_000,
  parameter int unsigned STEP        = 1,
  parameter int unsigned SWITCH_MODE = 0,
  parameter int unsigned SEL_LIMPEZA = 3,
  parameter int unsigned SEL_REGA01  = 1,
  parameter int unsigned SEL_REGA10  = 0,
  parameter int unsigned SEL_IDLE    = 3,
  parameter int unsigned SEL_DEFAULT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       rega,
  input  logic [1:0]       limpeza,
  input  logic             erro,
  input  logic             VE,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic             tick,
  output logic             new_clock,
  output logic [SEL_W-1:0] cur_sel,
  output logic             sel_changed
);

  localparam int unsigned NumRates = 1 << SEL_W;
  // Bits needed to hold BASE_DIV; the slowest rate adds MaxShift more.
  localparam int unsigned BaseBits = $clog2(BASE_DIV + 1);
  localparam int unsigned MaxShift = (NumRates - 1) * STEP;
  localparam bit          Immediate = (SWITCH_MODE != 0);

  localparam logic [SEL_W-1:0] SelLimpeza = SEL_W'(SEL_LIMPEZA);
  localparam logic [SEL_W-1:0] SelRega01  = SEL_W'(SEL_REGA01);
  localparam logic [SEL_W-1:0] SelRega10  = SEL_W'(SEL_REGA10);
  localparam logic [SEL_W-1:0] SelIdle    = SEL_W'(SEL_IDLE);
  localparam logic [SEL_W-1:0] SelDefault = SEL_W'(SEL_DEFAULT);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (BASE_DIV < 2) begin : g_err_base_div
    $error("rate_tick_selector: BASE_DIV must be at least 2");
  end

  if (BaseBits + MaxShift > CNT_W) begin : g_err_cnt_width
    $error("rate_tick_selector: slowest period does not fit in CNT_W bits");
  end

  if ((SEL_LIMPEZA >= NumRates) || (SEL_REGA01 >= NumRates) || (SEL_REGA10 >= NumRates) ||
      (SEL_IDLE >= NumRates) || (SEL_DEFAULT >= NumRates)) begin : g_err_sel_range
    $error("rate_tick_selector: a SEL_* rate code does not fit in SEL_W bits");
  end

  // ---------------------------------------------------------------------------
  // Period table: terminal count (P-1) of every rate, all constants
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] last_cnt [NumRates];

  for (genvar k = 0; k < NumRates; k++) begin : g_period
    localparam logic [CNT_W-1:0] Period = CNT_W'(BASE_DIV) << (k * STEP);
    assign last_cnt[k] = Period - CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] req_sel_d, req_sel_q;
  logic [SEL_W-1:0] cur_sel_d, cur_sel_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             tick_d, tick_q;
  logic             new_clock_d, new_clock_q;
  logic             sel_changed_d, sel_changed_q;

  logic             terminal;
  logic             sel_differs;

  // Only the cleaning-active bit takes part in the rate choice.
  logic unused_limpeza;
  assign unused_limpeza = limpeza[0];

  // ---------------------------------------------------------------------------
  // Request priority encoder (registered into req_sel_q)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_sel_d = SelDefault;
    if (force_en) begin
      req_sel_d = force_sel;
    end else if (limpeza[1]) begin
      req_sel_d = SelLimpeza;
    end else if (!erro && (rega == 2'b01)) begin
      req_sel_d = SelRega01;
    end else if (!erro && (rega == 2'b10)) begin
      req_sel_d = SelRega10;
    end else if (!erro && (rega == 2'b00) && !VE) begin
      req_sel_d = SelIdle;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and rate switching
  // ---------------------------------------------------------------------------
  assign terminal    = (cnt_q == last_cnt[cur_sel_q]);
  assign sel_differs = (req_sel_q != cur_sel_q);

  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    tick_d        = 1'b0;
    new_clock_d   = new_clock_q;
    cur_sel_d     = cur_sel_q;
    sel_changed_d = 1'b0;

    if (terminal) begin
      // Boundary: emit the tick and, if a new rate is pending, start the next
      // period already at the new rate. This wins over an immediate switch.
      cnt_d       = '0;
      tick_d      = 1'b1;
      new_clock_d = ~new_clock_q;
      if (sel_differs) begin
        cur_sel_d     = req_sel_q;
        sel_changed_d = 1'b1;
      end
    end else if (Immediate && sel_differs) begin
      // Mid-period switch: restart the count, no tick, new_clock holds.
      cnt_d         = '0;
      cur_sel_d     = req_sel_q;
      sel_changed_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_sel_q     <= SelDefault;
      cur_sel_q     <= SelDefault;
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      new_clock_q   <= 1'b0;
      sel_changed_q <= 1'b0;
    end else begin
      req_sel_q     <= req_sel_d;
      cur_sel_q     <= cur_sel_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      new_clock_q   <= new_clock_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  // All outputs come straight from flops.
  assign tick        = tick_q;
  assign new_clock   = new_clock_q;
  assign cur_sel     = cur_sel_q;
  assign sel_changed = sel_changed_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // Every period is at least 2 cycles, so ticks never come back to back.
  a_tick_single: assert property (@(posedge clock) disable iff (reset) tick_q |=> !tick_q);

  // The counter never runs past the terminal count of the active rate.
  a_cnt_range: assert property (@(posedge clock) disable iff (reset)
    cnt_q <= last_cnt[cur_sel_q]);

  // With boundary switching a rate change always coincides with a tick.
  a_boundary_switch: assert property (@(posedge clock) disable iff (reset)
    (!Immediate && sel_changed_q) |-> tick_q);
`endif

endmodule

// File: tb/tb_rate_tick_selector.sv
// Bench for rate_tick_selector: one instance per switch mode, same stimulus,
// BASE_DIV=4 and STEP=1 (periods 4/8/16/32). A time-based reference model
// predicts every output of both instances on every cycle.
module tb_rate_tick_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] rega, limpeza, force_sel;
  logic       erro, ve, force_en;

  logic       tick0, nclk0, chg0, tick1, nclk1, chg1;
  logic [1:0] cur0, cur1;

  rate_tick_selector #(
    .SEL_W(2), .CNT_W(8), .BASE_DIV(4), .STEP(1), .SWITCH_MODE(0)
  ) u_dut_m0 (
    .clock(clk), .reset(reset), .rega(rega), .limpeza(limpeza), .erro(erro), .VE(ve),
    .force_en(force_en), .force_sel(force_sel),
    .tick(tick0), .new_clock(nclk0), .cur_sel(cur0), .sel_changed(chg0)
  );

  rate_tick_selector #(
    .SEL_W(2), .CNT_W(8), .BASE_DIV(4), .STEP(1), .SWITCH_MODE(1)
  ) u_dut_m1 (
    .clock(clk), .reset(reset), .rega(rega), .limpeza(limpeza), .erro(erro), .VE(ve),
    .force_en(force_en), .force_sel(force_sel),
    .tick(tick1), .new_clock(nclk1), .cur_sel(cur1), .sel_changed(chg1)
  );

  logic [4:0] obs [2];
  assign obs[0] = {tick0, nclk0, cur0, chg0};
  assign obs[1] = {tick1, nclk1, cur1, chg1};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: absolute edge numbers, next expected tick edge per mode.
  int         edge_n = 0;
  int         m_next [2];
  logic [1:0] m_req;
  logic [1:0] m_sel  [2];
  bit         m_tick [2];
  bit         m_nclk [2];
  bit         m_chg  [2];

  function automatic logic [1:0] prio();
    if (force_en)                          return force_sel;
    if (limpeza[1])                        return 2'd3;
    if (!erro && rega == 2'b01)            return 2'd1;
    if (!erro && rega == 2'b10)            return 2'd0;
    if (!erro && rega == 2'b00 && !ve)     return 2'd3;
    return 2'd0;
  endfunction

  function automatic int per(logic [1:0] s);
    return 4 << s;
  endfunction

  // Cycles elapsed in the current period of mode m (the DUT's count).
  function automatic int pos(int m);
    return edge_n - (m_next[m] - per(m_sel[m]));
  endfunction

  function automatic logic [4:0] exp_vec(int m);
    return {m_tick[m], m_nclk[m], m_sel[m], m_chg[m]};
  endfunction

  // Advance one clock edge, update the model, return 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_sel[m]  = 2'd0;
        m_tick[m] = 1'b0;
        m_nclk[m] = 1'b0;
        m_chg[m]  = 1'b0;
        m_next[m] = edge_n + per(2'd0);
      end else begin
        m_tick[m] = 1'b0;
        m_chg[m]  = 1'b0;
        if (edge_n == m_next[m]) begin
          m_tick[m] = 1'b1;
          m_nclk[m] = ~m_nclk[m];
          if (m_req != m_sel[m]) begin
            m_sel[m] = m_req;
            m_chg[m] = 1'b1;
          end
          m_next[m] = edge_n + per(m_sel[m]);
        end else if (m == 1 && m_req != m_sel[m]) begin
          m_sel[m]  = m_req;
          m_chg[m]  = 1'b1;
          m_next[m] = edge_n + per(m_sel[m]);
        end
      end
    end
    m_req = reset ? 2'd0 : prio();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rega = 2'b00; limpeza = 2'b00; erro = 1'b1; ve = 1'b0;
    force_en = 1'b0; force_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== 5'b0) begin
          n_err++;
          $display("FAIL reset_values mode%0d: got %b want 00000", m, obs[m]);
        end
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL reset_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      n_vec++;
      if ({tick0, nclk0, tick1, nclk1} !==
          {2{(i % 4) == 0, ((i / 4) % 2) == 1}}) begin
        n_err++;
        $display("FAIL first_ticks cycle %0d: got %b want %b", i, {tick0, nclk0, tick1, nclk1},
                 {2{(i % 4) == 0, ((i / 4) % 2) == 1}});
      end
    end
  endtask

  task automatic test_priority();
    int ticks;
    limpeza = 2'b10; rega = 2'b01; erro = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 1) limpeza = 2'b00;
      if (ph == 2) erro = 1'b1;
      ticks = 0;
      for (int i = 0; i < 144; i++) begin
        step();
        for (int m = 0; m < 2; m++) begin
          n_vec++;
          if (obs[m] !== exp_vec(m)) begin
            n_err++;
            $display("FAIL priority_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                     exp_vec(m));
          end
        end
        if (i >= 80 && tick0 === 1'b1) ticks++;
      end
      n_vec++;
      if ({cur0, cur1} !== {2{(ph == 0) ? 2'd3 : (ph == 1) ? 2'd1 : 2'd0}}) begin
        n_err++;
        $display("FAIL priority_sel phase %0d: got %0d/%0d want %0d", ph, cur0, cur1,
                 (ph == 0) ? 3 : (ph == 1) ? 1 : 0);
      end
      n_vec++;
      if (ticks != ((ph == 0) ? 2 : (ph == 1) ? 8 : 16)) begin
        n_err++;
        $display("FAIL priority_ticks phase %0d: got %0d want %0d", ph, ticks,
                 (ph == 0) ? 2 : (ph == 1) ? 8 : 16);
      end
    end
  endtask

  task automatic test_boundary_switch();
    bit found = 1'b0;
    logic [3:0] want;
    limpeza = 2'b10; erro = 1'b0; rega = 2'b00; force_en = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL boundary_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      if (m_sel[0] == 2'd3 && pos(0) == 1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL boundary_align: got no cnt=1 of period 32 want one within 200 cycles");
    end
    limpeza = 2'b00; erro = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL boundary_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      want = {i >= 31 && ((i - 31) % 4) == 0, (i >= 31) ? 2'd0 : 2'd3, i == 31};
      n_vec++;
      if ({tick0, cur0, chg0} !== want) begin
        n_err++;
        $display("FAIL boundary_switch cycle %0d: got %b want %b (tick,sel,chg)", i,
                 {tick0, cur0, chg0}, want);
      end
    end
  endtask

  task automatic test_immediate_switch();
    bit found = 1'b0;
    bit saved;
    logic [4:0] want;
    limpeza = 2'b10; erro = 1'b0; rega = 2'b00;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL immediate_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      if (m_sel[1] == 2'd3 && pos(1) == 10) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL immediate_align: got no cnt=10 of period 32 want one within 200 cycles");
    end
    saved = m_nclk[1];
    limpeza = 2'b00; rega = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL immediate_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      want = {i == 10, (i >= 10) ? ~saved : saved, (i >= 2) ? 2'd1 : 2'd3, i == 2};
      n_vec++;
      if (obs[1] !== want) begin
        n_err++;
        $display("FAIL immediate_switch cycle %0d: got %b want %b (tick,nclk,sel,chg)", i,
                 obs[1], want);
      end
    end
  endtask

  task automatic test_override_glitch();
    bit found = 1'b0;
    force_en = 1'b1; force_sel = 2'd2; limpeza = 2'b10;
    for (int i = 0; i < 60; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL override_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
    end
    n_vec++;
    if ({cur0, cur1} !== {2'd2, 2'd2}) begin
      n_err++;
      $display("FAIL override_sel: got %0d/%0d want 2/2", cur0, cur1);
    end
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL override_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      if (pos(0) == 3) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL glitch_align: got no cnt=3 of period 16 want one within 40 cycles");
    end
    for (int i = 0; i < 21; i++) begin
      force_sel = (i == 0) ? 2'd1 : 2'd2;
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL glitch_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      n_vec++;
      if ({cur0, chg0} !== {2'd2, 1'b0}) begin
        n_err++;
        $display("FAIL glitch_ignored cycle %0d: got sel %0d chg %b want sel 2 chg 0", i, cur0,
                 chg0);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL reset_mid_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      if (m_sel[0] == 2'd2 && pos(0) == 5) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid_align: got no cnt=5 of period 16 want one within 40 cycles");
    end
    reset = 1'b1; force_en = 1'b0; limpeza = 2'b00; erro = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (obs[m] !== 5'b0) begin
        n_err++;
        $display("FAIL reset_mid_values mode%0d: got %b want 00000", m, obs[m]);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (obs[m] !== exp_vec(m)) begin
          n_err++;
          $display("FAIL reset_mid_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                   exp_vec(m));
        end
      end
      n_vec++;
      if ({tick0, cur0, tick1, cur1} !== {2{(i % 4) == 0, 2'd0}}) begin
        n_err++;
        $display("FAIL reset_mid_restart cycle %0d: got %b want %b", i,
                 {tick0, cur0, tick1, cur1}, {2{(i % 4) == 0, 2'd0}});
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      rega      = 2'($urandom_range(3, 0));
      limpeza   = 2'($urandom_range(3, 0));
      erro      = ($urandom_range(3, 0) == 0);
      ve        = $urandom_range(1, 0) == 1;
      force_en  = ($urandom_range(3, 0) == 0);
      force_sel = 2'($urandom_range(3, 0));
      reset     = ($urandom_range(29, 0) == 0);
      hold      = reset ? 1 : int'($urandom_range(40, 1));
      for (int i = 0; i < hold; i++) begin
        step();
        for (int m = 0; m < 2; m++) begin
          n_vec++;
          if (obs[m] !== exp_vec(m)) begin
            n_err++;
            $display("FAIL random_model mode%0d edge %0d: got %b want %b", m, edge_n, obs[m],
                     exp_vec(m));
          end
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_boundary_switch();
    test_immediate_switch();
    test_override_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
